// File: rtl/chunked_serial_adder.sv
// Multi-cycle unsigned adder: walks two WIDTH-bit operands CHUNK bits per clock
// through a ripple chain of 1-bit full-adder cells, carrying between slices
// in a register. Result and final carry are held until the next accepted start.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // state  | meaning
  // S_IDLE | waiting for start; sum/cout hold the last result
  // S_ADD  | one slice added per cycle, carry kept in r_carry
  // S_DONE | result valid, done pulses for this single cycle

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_busy;
  logic   r_done;
  logic   w_busy_nxt;
  logic   w_done_nxt;

  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDXW-1:0]  r_idx;

  int               w_base;
  logic [CHUNK-1:0] w_slice_a;
  logic [CHUNK-1:0] w_slice_b;
  logic [CHUNK-1:0] w_slice_sum;
  logic [CHUNK:0]   w_chain;
  logic             w_last;

  assign w_base    = int'(r_idx) * CHUNK;
  assign w_slice_a = r_op_a[w_base +: CHUNK];
  assign w_slice_b = r_op_b[w_base +: CHUNK];
  assign w_last    = (r_idx == LAST_IDX);

  // Ripple chain of full-adder cells fed by the registered inter-slice carry
  assign w_chain[0] = r_carry;
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign w_slice_sum[gi] = w_slice_a[gi] ^ w_slice_b[gi] ^ w_chain[gi];
    assign w_chain[gi+1]   = (w_slice_a[gi] & w_slice_b[gi]) |
                             (w_chain[gi] & (w_slice_a[gi] ^ w_slice_b[gi]));
  end

  // State register plus registered busy/done so outputs come straight from flops
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state decode; busy/done are derived from the state being entered
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_ADD;
      S_ADD:   if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_ADD);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Datapath: operand capture on start, one slice written back per ADD cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op_a  <= i_a;
            r_op_b  <= i_b;
            r_carry <= i_cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        S_ADD: begin
          r_sum[w_base +: CHUNK] <= w_slice_sum;
          r_carry                <= w_chain[CHUNK];
          if (w_last) begin
            r_cout <= w_chain[CHUNK];
          end else begin
            // idx stops on the last slice so it never wraps mid-operation
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule
